// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared fetch-stage types and constants
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory req/gnt + rvalid handshake
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemGnt;
  logic            ImemRValid;
  logic [31:0]     ImemRData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemGnt,
    input  ImemRValid,
    input  ImemRData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemGnt,
    output ImemRValid,
    output ImemRData
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with load/stall/flush/bubble
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  // Flush and bubble only kill the instruction; PCD/PCPlus4D keep their last values.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        instr_d = instr_i;
        pc_d    = pc_i;
        pc4_d   = pc_i + XLEN'(4);
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PCF, single-outstanding imem fetch, IF/ID
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  fetch_unit_if.master    imem,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchBusy
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] pcreq_q, pcreq_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic            kill_q, kill_d;

  logic            req;
  logic            fire;
  logic            load;
  logic [31:0]     load_instr;
  logic [XLEN-1:0] load_pc;

  // rst_n gates the request so nothing is issued while reset is held.
  assign req            = rst_n & (state_q == REQ) & ~StallF & ~PCSrcE;
  assign fire           = req & imem.ImemGnt;
  assign imem.ImemReq   = req;
  assign imem.ImemAddr  = pcf_q;
  assign FetchBusy      = (state_q != REQ);

  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    pcreq_d      = pcreq_q;
    kill_d       = kill_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    load         = 1'b0;
    load_instr   = imem.ImemRData;
    load_pc      = pcreq_q;

    unique case (state_q)
      REQ: begin
        if (fire) begin
          pcreq_d = pcf_q;
          pcf_d   = pcf_q + XLEN'(4);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem.ImemRValid) begin
          kill_d  = 1'b0;
          state_d = REQ;
          // A flushed response is dropped rather than parked in the hold buffer.
          if (!(kill_q | PCSrcE | FlushD)) begin
            if (!StallD) begin
              load = 1'b1;
            end else begin
              hold_instr_d = imem.ImemRData;
              hold_pc_d    = pcreq_q;
              state_d      = HOLD;
            end
          end
        end else if (PCSrcE) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        load_instr = hold_instr_q;
        load_pc    = hold_pc_q;
        if (PCSrcE | FlushD) begin
          state_d = REQ;
        end else if (!StallD) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    if (PCSrcE) begin
      pcf_d = PCTargetE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pcf_q        <= RESET_PC;
      pcreq_q      <= '0;
      kill_q       <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      pcreq_q      <= pcreq_d;
      kill_q       <= kill_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .stall_i   (StallD),
    .flush_i   (FlushD),
    .instr_i   (load_instr),
    .pc_i      (load_pc),
    .instr_o   (InstrD),
    .pc_o      (PCD),
    .pc_plus4_o(PCPlus4D),
    .valid_o   (ValidD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a transaction-level model
module tb_fetch_unit;
  import pipeline_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusy;

  fetch_unit_if #(.XLEN(XLEN)) imem ();

  fetch_unit #(
    .XLEN    (XLEN),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .imem     (imem),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD),
    .FetchBusy(FetchBusy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: expected PC, the one fetch in flight, a parked word, and the IF/ID contents.
  logic [31:0] m_pc;
  bit          m_out;
  logic [31:0] m_out_addr;
  bit          m_stale;
  bit          m_held;
  logic [31:0] m_held_instr, m_held_pc;
  logic [31:0] m_instr, m_pcd, m_pc4;
  bit          m_valid;
  bit          exp_req;
  bit          stale_rvalid = 0;
  bit          did_rst = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_pc    = 32'h0;
    m_out   = 0;
    m_stale = 0;
    m_held  = 0;
    m_instr = NOP_INSTR;
    m_pcd   = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 0;
  endtask

  task automatic drive(input bit clean);
    StallF = !clean && ($urandom_range(0, 4) == 0);
    StallD = !clean && ($urandom_range(0, 3) == 0);
    FlushD = !clean && ($urandom_range(0, 11) == 0);
    PCSrcE = !clean && ($urandom_range(0, 9) == 0);
    case ($urandom_range(0, 3))
      0:       PCTargetE = 32'hFFFF_FFF4 + (32'($urandom_range(0, 2)) << 2);
      1:       PCTargetE = $urandom;
      default: PCTargetE = 32'($urandom_range(0, 1023)) << 2;
    endcase
    imem.ImemGnt    = clean || ($urandom_range(0, 9) < 7);
    imem.ImemRValid = m_out && (clean || ($urandom_range(0, 9) < 6));
    imem.ImemRData  = m_out ? mem_word(m_out_addr) : $urandom;
    if (stale_rvalid) begin
      imem.ImemRValid = 1'b1;
      imem.ImemRData  = 32'hDEAD_BEEF;
      stale_rvalid    = 0;
    end
  endtask

  task automatic model_step();
    bit          fired, deliver;
    logic [31:0] d_instr, d_pc;
    fired   = exp_req && imem.ImemGnt;
    deliver = 0;
    d_instr = 32'h0;
    d_pc    = 32'h0;
    if (m_out && imem.ImemRValid) begin
      m_out = 0;
      if (!(m_stale || PCSrcE || FlushD)) begin
        if (!StallD) begin
          deliver = 1; d_instr = mem_word(m_out_addr); d_pc = m_out_addr;
        end else begin
          m_held = 1; m_held_instr = mem_word(m_out_addr); m_held_pc = m_out_addr;
        end
      end
    end else if (m_held) begin
      if (PCSrcE || FlushD) m_held = 0;
      else if (!StallD) begin
        m_held = 0; deliver = 1; d_instr = m_held_instr; d_pc = m_held_pc;
      end
    end else if (m_out && PCSrcE) begin
      m_stale = 1;
    end
    if (fired) begin
      m_out = 1; m_out_addr = m_pc; m_stale = 0;
    end
    if (PCSrcE) m_pc = PCTargetE;
    else if (fired) m_pc = m_pc + 32'd4;
    if (FlushD) begin
      m_instr = NOP_INSTR; m_valid = 0;
    end else if (!StallD) begin
      if (deliver) begin
        m_instr = d_instr; m_pcd = d_pc; m_pc4 = d_pc + 32'd4; m_valid = 1;
      end else begin
        m_instr = NOP_INSTR; m_valid = 0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_req"},   32'(imem.ImemReq), 32'd0);
    chk({pfx, "_addr"},  imem.ImemAddr, 32'h0);
    chk({pfx, "_instr"}, InstrD, NOP_INSTR);
    chk({pfx, "_pcd"},   PCD, 32'h0);
    chk({pfx, "_pc4"},   PCPlus4D, 32'h0);
    chk({pfx, "_valid"}, 32'(ValidD), 32'd0);
    chk({pfx, "_busy"},  32'(FetchBusy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive(1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!did_rst && cyc >= 1500 && m_out) begin
        did_rst = 1;
        rst_n   = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        stale_rvalid = 1;
      end
      drive(cyc < 10);
      #1;
      exp_req = !m_out && !m_held && !StallF && !PCSrcE;
      chk("req",  32'(imem.ImemReq), 32'(exp_req));
      chk("addr", imem.ImemAddr, m_pc);
      chk("busy", 32'(FetchBusy), 32'(m_out || m_held));
      model_step();
      @(posedge clk);
      #1;
      chk("instr", InstrD, m_instr);
      chk("valid", 32'(ValidD), 32'(m_valid));
      chk("pcd",   PCD, m_pcd);
      chk("pc4",   PCPlus4D, m_pc4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
